// File: rtl/decode_stage_if.sv
// Fetch/execute-facing bundle of the decode stage: fetch handshake in, decoded bundle out.
interface decode_stage_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned OPCODE_BITS = 5,
  parameter int unsigned STATUS_BITS = 6
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]    pc_in;
  logic [STATUS_BITS-1:0] status;
  logic                   out_valid;
  logic                   out_ready;
  logic [OPCODE_BITS-1:0] opcode;
  logic [DATA_WIDTH-1:0]  literal;
  logic [SEL_WIDTH-1:0]   rd_sel1;
  logic [SEL_WIDTH-1:0]   rd_sel2;
  logic [SEL_WIDTH-1:0]   wr_sel;
  logic                   rd_en1;
  logic                   rd_en2;
  logic                   wr_en;
  logic                   sel_reg_in_alu_decoder;
  logic                   stat_wr_en;
  logic                   cnt_wr_en;
  logic                   add_offset;
  logic [PC_WIDTH-1:0]    pc_target;
  logic                   flush;
  logic                   stack_overflow;
  logic                   stack_underflow;

  modport slave (
    input  in_valid, instruction, pc_in, status, out_ready,
    output in_ready, out_valid, opcode, literal, rd_sel1, rd_sel2, wr_sel,
           rd_en1, rd_en2, wr_en, sel_reg_in_alu_decoder, stat_wr_en,
           cnt_wr_en, add_offset, pc_target, flush, stack_overflow, stack_underflow
  );

  modport master (
    output in_valid, instruction, pc_in, status, out_ready,
    input  in_ready, out_valid, opcode, literal, rd_sel1, rd_sel2, wr_sel,
           rd_en1, rd_en2, wr_en, sel_reg_in_alu_decoder, stat_wr_en,
           cnt_wr_en, add_offset, pc_target, flush, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/decode_stage.sv
// Registered, handshaked instruction decoder with return-address stack,
// status-hazard stall and one-instruction branch-shadow discard.
module decode_stage #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned OPCODE_BITS = 5,
  parameter int unsigned OP1_POS     = 9,
  parameter int unsigned OP2_POS     = 4,
  parameter int unsigned STATUS_BITS = 6,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned STATUS_LAT  = 1
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);
  localparam int unsigned AW   = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W = AW + 1;
  localparam int unsigned HZ_W = (STATUS_LAT > 1) ? $clog2(STATUS_LAT + 1) : 1;

  localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(8'h01);
  localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(8'h02);
  localparam logic [OPCODE_BITS-1:0] OP_AND  = OPCODE_BITS'(8'h03);
  localparam logic [OPCODE_BITS-1:0] OP_OR   = OPCODE_BITS'(8'h04);
  localparam logic [OPCODE_BITS-1:0] OP_NOT  = OPCODE_BITS'(8'h05);
  localparam logic [OPCODE_BITS-1:0] OP_XOR  = OPCODE_BITS'(8'h06);
  localparam logic [OPCODE_BITS-1:0] OP_SHL  = OPCODE_BITS'(8'h07);
  localparam logic [OPCODE_BITS-1:0] OP_SHR  = OPCODE_BITS'(8'h08);
  localparam logic [OPCODE_BITS-1:0] OP_VAL  = OPCODE_BITS'(8'h09);
  localparam logic [OPCODE_BITS-1:0] OP_GOTO = OPCODE_BITS'(8'h10);
  localparam logic [OPCODE_BITS-1:0] OP_IFZ  = OPCODE_BITS'(8'h11);
  localparam logic [OPCODE_BITS-1:0] OP_IFNZ = OPCODE_BITS'(8'h12);
  localparam logic [OPCODE_BITS-1:0] OP_IFEQ = OPCODE_BITS'(8'h13);
  localparam logic [OPCODE_BITS-1:0] OP_IFST = OPCODE_BITS'(8'h14);
  localparam logic [OPCODE_BITS-1:0] OP_IFGT = OPCODE_BITS'(8'h15);
  localparam logic [OPCODE_BITS-1:0] OP_CALL = OPCODE_BITS'(8'h16);
  localparam logic [OPCODE_BITS-1:0] OP_RET  = OPCODE_BITS'(8'h17);

  typedef enum logic {S_IDLE = 1'b0, S_STALL = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_out_valid, r_flush, r_shadow, r_ovf, r_unf;
  logic [OPCODE_BITS-1:0] r_opcode;
  logic [DATA_WIDTH-1:0]  r_literal;
  logic [SEL_WIDTH-1:0]   r_rd_sel1, r_rd_sel2, r_wr_sel;
  logic                   r_rd_en1, r_rd_en2, r_wr_en, r_sel_alu, r_stat_wr_en;
  logic                   r_cnt_wr_en, r_add_offset;
  logic [PC_WIDTH-1:0]    r_pc_target;
  logic [HZ_W-1:0]        r_hz;
  logic [SP_W-1:0]        r_sp;
  logic [PC_WIDTH-1:0]    r_stack [STACK_DEPTH];

  logic [OPCODE_BITS-1:0] w_op;
  logic [SEL_WIDTH-1:0]   w_op1, w_op2;
  logic [DATA_WIDTH-1:0]  w_lit;
  logic [AW-1:0]          w_push_idx, w_pop_idx;
  logic w_rd_en1, w_rd_en2, w_wr_en, w_sel_alu, w_stat_wr_en, w_cnt_wr_en, w_add_offset;
  logic w_is_cond, w_push, w_pop, w_ovf, w_unf;
  logic [PC_WIDTH-1:0]    w_pc_target;
  logic w_in_ready, w_stall_req, w_accept, w_issue, w_unused;

  assign w_op       = bus.instruction[INSTR_WIDTH-1 -: OPCODE_BITS];
  assign w_op1      = bus.instruction[OP1_POS -: SEL_WIDTH];
  assign w_op2      = bus.instruction[OP2_POS -: SEL_WIDTH];
  assign w_lit      = bus.instruction[DATA_WIDTH-1:0];
  assign w_push_idx = r_sp[AW-1:0];
  assign w_pop_idx  = AW'(r_sp - SP_W'(1));
  assign w_unused   = ^{bus.instruction, bus.status};

  // Instruction decode; control-transfer results depend on live status and stack.
  always_comb begin
    w_rd_en1     = 1'b0;
    w_rd_en2     = 1'b0;
    w_wr_en      = 1'b0;
    w_sel_alu    = 1'b0;
    w_stat_wr_en = 1'b0;
    w_cnt_wr_en  = 1'b0;
    w_add_offset = 1'b0;
    w_pc_target  = '0;
    w_is_cond    = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_ovf        = 1'b0;
    w_unf        = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        w_rd_en1 = 1'b1; w_rd_en2 = 1'b1; w_wr_en = 1'b1;
        w_sel_alu = 1'b1; w_stat_wr_en = 1'b1;
      end
      OP_NOT, OP_SHL, OP_SHR: begin
        w_rd_en1 = 1'b1; w_wr_en = 1'b1; w_sel_alu = 1'b1; w_stat_wr_en = 1'b1;
      end
      OP_VAL: w_wr_en = 1'b1;
      OP_GOTO: begin
        w_cnt_wr_en = 1'b1;
        w_pc_target = PC_WIDTH'(w_lit);
      end
      OP_IFZ, OP_IFNZ, OP_IFEQ, OP_IFST, OP_IFGT: begin
        w_is_cond = 1'b1;
        case (w_op)
          OP_IFZ:  w_cnt_wr_en = bus.status[2];
          OP_IFNZ: w_cnt_wr_en = !bus.status[2];
          OP_IFEQ: w_cnt_wr_en = bus.status[3];
          OP_IFST: w_cnt_wr_en = bus.status[5];
          default: w_cnt_wr_en = bus.status[4];
        endcase
        w_add_offset = w_cnt_wr_en;
      end
      OP_CALL: begin
        w_cnt_wr_en = 1'b1;
        w_pc_target = PC_WIDTH'(w_lit);
        if (r_sp == SP_W'(STACK_DEPTH)) w_ovf = 1'b1;
        else                            w_push = 1'b1;
      end
      OP_RET: begin
        if (r_sp == '0) begin
          w_unf = 1'b1;
        end else begin
          w_pop       = 1'b1;
          w_cnt_wr_en = 1'b1;
          w_pc_target = r_stack[w_pop_idx];
        end
      end
      default: ;
    endcase
  end

  // Hazard FSM: a conditional branch waits until pending status writes have landed.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_stall_req = bus.in_valid & w_is_cond & (r_hz != '0);
    case (r_state)
      S_IDLE: begin
        if (w_stall_req) w_state_nxt = S_STALL;
        else             w_in_ready  = !r_out_valid | bus.out_ready;
      end
      S_STALL: if (r_hz == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_issue  = w_accept & !r_shadow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0; r_flush <= 1'b0; r_shadow <= 1'b0;
      r_ovf <= 1'b0; r_unf <= 1'b0;
      r_opcode <= '0; r_literal <= '0;
      r_rd_sel1 <= '0; r_rd_sel2 <= '0; r_wr_sel <= '0;
      r_rd_en1 <= 1'b0; r_rd_en2 <= 1'b0; r_wr_en <= 1'b0;
      r_sel_alu <= 1'b0; r_stat_wr_en <= 1'b0;
      r_cnt_wr_en <= 1'b0; r_add_offset <= 1'b0; r_pc_target <= '0;
      r_hz <= '0; r_sp <= '0;
    end else begin
      r_flush <= 1'b0;
      if (w_accept) begin
        if (r_shadow) begin
          r_out_valid <= 1'b0;
          r_shadow    <= 1'b0;
        end else begin
          r_out_valid  <= 1'b1;
          r_opcode     <= w_op;
          r_literal    <= w_lit;
          r_rd_sel1    <= w_op1;
          r_rd_sel2    <= w_op2;
          r_wr_sel     <= w_op1;
          r_rd_en1     <= w_rd_en1;
          r_rd_en2     <= w_rd_en2;
          r_wr_en      <= w_wr_en;
          r_sel_alu    <= w_sel_alu;
          r_stat_wr_en <= w_stat_wr_en;
          r_cnt_wr_en  <= w_cnt_wr_en;
          r_add_offset <= w_add_offset;
          r_pc_target  <= w_pc_target;
          r_flush      <= w_cnt_wr_en;
          r_shadow     <= w_cnt_wr_en;
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_issue & w_ovf) r_ovf <= 1'b1;
      if (w_issue & w_unf) r_unf <= 1'b1;
      if (w_issue & w_push)     r_sp <= r_sp + SP_W'(1);
      else if (w_issue & w_pop) r_sp <= r_sp - SP_W'(1);
      if (w_issue & w_stat_wr_en) r_hz <= HZ_W'(STATUS_LAT);
      else if (r_hz != '0)        r_hz <= r_hz - HZ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue & w_push) r_stack[w_push_idx] <= bus.pc_in + PC_WIDTH'(1);
  end

  assign bus.in_ready               = w_in_ready;
  assign bus.out_valid              = r_out_valid;
  assign bus.opcode                 = r_opcode;
  assign bus.literal                = r_literal;
  assign bus.rd_sel1                = r_rd_sel1;
  assign bus.rd_sel2                = r_rd_sel2;
  assign bus.wr_sel                 = r_wr_sel;
  assign bus.rd_en1                 = r_rd_en1;
  assign bus.rd_en2                 = r_rd_en2;
  assign bus.wr_en                  = r_wr_en;
  assign bus.sel_reg_in_alu_decoder = r_sel_alu;
  assign bus.stat_wr_en             = r_stat_wr_en;
  assign bus.cnt_wr_en              = r_cnt_wr_en;
  assign bus.add_offset             = r_add_offset;
  assign bus.pc_target              = r_pc_target;
  assign bus.flush                  = r_flush;
  assign bus.stack_overflow         = r_ovf;
  assign bus.stack_underflow        = r_unf;
endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: handshake, decode, hazard stall, shadow, stack.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [4:0] OP_NOP = 5'h00, OP_ADD = 5'h01, OP_SUB = 5'h02, OP_OR = 5'h04;
  localparam logic [4:0] OP_VAL = 5'h09, OP_IFZ = 5'h11, OP_IFNZ = 5'h12;
  localparam logic [4:0] OP_CALL = 5'h16, OP_RET = 5'h17;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register op: opcode[15:11], op1[9:8], op2[4:3].
  function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [1:0] a, input logic [1:0] b);
    logic [15:0] w;
    w = '0; w[15:11] = op; w[9:8] = a; w[4:3] = b;
    return w;
  endfunction

  // Literal op: opcode[15:11], op1[9:8], literal[7:0].
  function automatic logic [15:0] enc_l(input logic [4:0] op, input logic [1:0] a, input logic [7:0] lit);
    logic [15:0] w;
    w = '0; w[15:11] = op; w[9:8] = a; w[7:0] = lit;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [7:0] pc);
    bus.in_valid    = 1'b1;
    bus.instruction = ins;
    bus.pc_in       = pc;
    tick();
    bus.in_valid    = 1'b0;
  endtask

  task automatic shadow_slot(input string tag);
    issue(enc_r(OP_ADD, 2'd1, 2'd1), 8'hEE);
    check({tag, "_disc_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_disc_flush"}, 32'(bus.flush), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.instruction = '0; bus.pc_in = '0;
    bus.status = '0; bus.out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_opcode", 32'(bus.opcode), 32'd0);
    check("rst_flags", 32'({bus.stack_overflow, bus.stack_underflow, bus.flush}), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD r1,r2
    issue(enc_r(OP_ADD, 2'd1, 2'd2), 8'h00);
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_sels", 32'({bus.rd_sel1, bus.rd_sel2, bus.wr_sel}), 32'({2'd1, 2'd2, 2'd1}));
    check("add_ens", 32'({bus.rd_en1, bus.rd_en2, bus.wr_en, bus.stat_wr_en, bus.sel_reg_in_alu_decoder}), 32'h1F);
    check("add_ctl", 32'({bus.cnt_wr_en, bus.flush}), 32'd0);
    tick();
    check("add_drop", 32'(bus.out_valid), 32'd0);
    tick();

    // VAL r3,0x5A held by backpressure while OR waits
    bus.out_ready = 1'b0;
    issue(enc_l(OP_VAL, 2'd3, 8'h5A), 8'h01);
    bus.in_valid = 1'b1; bus.instruction = enc_r(OP_OR, 2'd0, 2'd1); bus.pc_in = 8'h02;
    #1;
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", 32'({bus.out_valid, bus.opcode, bus.wr_sel, bus.literal}), 32'({1'b1, OP_VAL, 2'd3, 8'h5A}));
      check("val_ens", 32'({bus.wr_en, bus.stat_wr_en, bus.sel_reg_in_alu_decoder}), 32'b100);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("or_issue", 32'({bus.out_valid, bus.opcode, bus.rd_sel2}), 32'({1'b1, OP_OR, 2'd1}));
    tick();
    check("or_once", 32'(bus.out_valid), 32'd0);
    tick();

    // SUB then IFZ: stall until status settles
    issue(enc_r(OP_SUB, 2'd1, 2'd2), 8'h03);
    bus.in_valid = 1'b1; bus.instruction = enc_l(OP_IFZ, 2'd0, 8'h05); bus.pc_in = 8'h04;
    #1;
    check("haz_hold", 32'(bus.in_ready), 32'd0);
    tick();
    bus.status = 6'b000100;
    check("stall_ready", 32'(bus.in_ready), 32'd0);
    check("stall_nobubble", 32'(bus.out_valid), 32'd0);
    tick();
    check("stall_exit", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("ifz_taken", 32'({bus.out_valid, bus.cnt_wr_en, bus.add_offset, bus.flush}), 32'hF);
    shadow_slot("ifz");
    bus.status = '0;
    tick();

    // CALL 0x40 from 0x10, then RET
    issue(enc_l(OP_CALL, 2'd0, 8'h40), 8'h10);
    check("call_ctl", 32'({bus.cnt_wr_en, bus.add_offset, bus.flush, bus.pc_target}), 32'({3'b101, 8'h40}));
    shadow_slot("call");
    issue(enc_l(OP_RET, 2'd0, 8'h00), 8'h40);
    check("ret_ctl", 32'({bus.cnt_wr_en, bus.add_offset, bus.pc_target}), 32'({2'b10, 8'h11}));
    check("ret_flags", 32'({bus.stack_overflow, bus.stack_underflow}), 32'd0);
    shadow_slot("ret");

    // Five nested CALLs overflow a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      issue(enc_l(OP_CALL, 2'd0, 8'(8'h80 + i)), 8'(8'h20 + 16 * i));
      check("ncall_tgt", 32'({bus.cnt_wr_en, bus.flush, bus.pc_target}), 32'({2'b11, 8'(8'h80 + i)}));
      check("ncall_ovf", 32'(bus.stack_overflow), (i == 4) ? 32'd1 : 32'd0);
      shadow_slot("ncall");
    end
    for (int i = 0; i < 4; i++) begin
      issue(enc_l(OP_RET, 2'd0, 8'h00), 8'(8'h90 + i));
      check("nret_tgt", 32'({bus.cnt_wr_en, bus.pc_target}), 32'({1'b1, 8'(8'h51 - 16 * i)}));
      check("nret_unf", 32'(bus.stack_underflow), 32'd0);
      shadow_slot("nret");
    end
    issue(enc_l(OP_RET, 2'd0, 8'h00), 8'h99);
    check("unf_ret", 32'({bus.out_valid, bus.cnt_wr_en, bus.flush, bus.stack_underflow}), 32'b1001);
    issue(enc_r(OP_NOP, 2'd0, 2'd0), 8'h9A);
    check("unf_noshadow", 32'(bus.out_valid), 32'd1);
    tick();

    // Reset while stalled
    issue(enc_r(OP_SUB, 2'd1, 2'd2), 8'hA0);
    bus.in_valid = 1'b1; bus.instruction = enc_l(OP_IFNZ, 2'd0, 8'h03); bus.pc_in = 8'hA1;
    tick();
    check("stall2_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("arst_bundle", 32'({bus.out_valid, bus.opcode, bus.stat_wr_en, bus.rd_en1}), 32'd0);
    check("arst_flags", 32'({bus.stack_overflow, bus.stack_underflow}), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    issue(enc_r(OP_ADD, 2'd3, 2'd0), 8'hB0);
    check("arst_resume", 32'({bus.out_valid, bus.opcode, bus.wr_sel}), 32'({1'b1, OP_ADD, 2'd3}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
